// File: rtl/m_uart_txq.sv
// m_uart_txq: buffered UART transmitter, circular FIFO feeding a start/data/[parity]/stop frame FSM
//   w_clk, w_rst_n       clock; asynchronous active-low reset
//   w_valid_i, w_data_i  producer handshake and character (DATA_BITS wide)
//   w_ready_o            FIFO not full (from registered occupancy only)
//   w_clr_i              clears the sticky overflow flag
//   w_txd_o              registered TX line, idle high
//   w_busy_o             frame FSM not idle
//   w_count_o            FIFO occupancy
//   w_ovf_o              sticky: character offered while the FIFO was full
// Optional macro UART_PARITY_EN adds an even-parity bit after the data bits.
module m_uart_txq #(
    parameter int CLK_DIV    = 40,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          w_clk,
    input  logic                          w_rst_n,
    input  logic                          w_valid_i,
    input  logic [DATA_BITS-1:0]          w_data_i,
    output logic                          w_ready_o,
    input  logic                          w_clr_i,
    output logic                          w_txd_o,
    output logic                          w_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   w_count_o,
    output logic                          w_ovf_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    logic par_q, par_d;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  ovf_q, txd_q, txd_d;
    logic [DW-1:0]         baud_q, baud_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  push, pop, tick, has, stop_end;

    assign w_ready_o = count_q != (AW+1)'(FIFO_DEPTH);
    assign push      = w_valid_i && w_ready_o;
    assign has       = count_q != '0;
    assign tick      = baud_q == DW'(CLK_DIV - 1);
    assign stop_end  = state_q == STOP && tick && bit_q == BW'(STOP_BITS - 1);
    // A new character is taken either from idle or straight out of the last stop bit,
    // so queued frames follow each other without an idle gap.
    assign pop       = has && (state_q == IDLE || stop_end);

    assign w_txd_o   = txd_q;
    assign w_busy_o  = state_q != IDLE;
    assign w_count_o = count_q;
    assign w_ovf_o   = ovf_q;

    always_comb begin
        state_d = state_q;
        txd_d   = txd_q;
        baud_d  = tick ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
            end
            START: if (tick) begin
                state_d = DATA;
                txd_d   = shift_q[0];
                shift_d = shift_q >> 1;
                bit_d   = '0;
            end
            DATA: if (tick) begin
                if (bit_q == BW'(DATA_BITS - 1)) begin
                    bit_d = '0;
`ifdef UART_PARITY_EN
                    state_d = PAR;
                    txd_d   = par_q;
`else
                    state_d = STOP;
                    txd_d   = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 1'b1;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
`ifdef UART_PARITY_EN
            PAR: if (tick) begin
                state_d = STOP;
                txd_d   = 1'b1;
            end
`endif
            STOP: if (tick) begin
                bit_d   = stop_end ? '0 : bit_q + 1'b1;
                state_d = stop_end ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = START;
            txd_d   = 1'b0;
            baud_d  = '0;
            shift_d = mem[rd_ptr_q];
`ifdef UART_PARITY_EN
            par_d   = ^mem[rd_ptr_q];
`endif
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q  <= IDLE;
            txd_q    <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
`ifdef UART_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            txd_q    <= txd_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            ovf_q    <= (w_valid_i && !w_ready_o) ? 1'b1 : w_clr_i ? 1'b0 : ovf_q;
`ifdef UART_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Storage has no reset: contents are meaningless once the pointers are cleared.
    always_ff @(posedge w_clk) begin
        if (push) mem[wr_ptr_q] <= w_data_i;
    end
endmodule

// File: tb/tb_m_uart_txq.sv
// tb_m_uart_txq: directed bench for m_uart_txq (8N1/depth-4 and 7-bit/2-stop instances, CLK_DIV=4)
module tb_m_uart_txq;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 10 + P;

    logic       clk = 1'b0;
    logic       rst_n, valid, clr, sel;
    logic [7:0] data;
    logic       valid_a, valid_b, ready_a, ready_b, txd_a, txd_b, busy_a, busy_b, ovf_a, ovf_b;
    logic [2:0] count_a;
    logic [4:0] count_b, count_s;
    logic       txd_s, busy_s, ready_s;

    assign valid_a = valid && !sel;
    assign valid_b = valid && sel;
    assign txd_s   = sel ? txd_b : txd_a;
    assign busy_s  = sel ? busy_b : busy_a;
    assign ready_s = sel ? ready_b : ready_a;
    assign count_s = sel ? count_b : {2'b00, count_a};

    always #5 clk = ~clk;

    m_uart_txq #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .w_clk(clk), .w_rst_n(rst_n), .w_valid_i(valid_a), .w_data_i(data),
        .w_ready_o(ready_a), .w_clr_i(clr), .w_txd_o(txd_a), .w_busy_o(busy_a),
        .w_count_o(count_a), .w_ovf_o(ovf_a));

    m_uart_txq #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
        .w_clk(clk), .w_rst_n(rst_n), .w_valid_i(valid_b), .w_data_i(data[6:0]),
        .w_ready_o(ready_b), .w_clr_i(clr), .w_txd_o(txd_b), .w_busy_o(busy_b),
        .w_count_o(count_b), .w_ovf_o(ovf_b));

    typedef struct {
        bit         sel;
        logic [7:0] d;
        logic [11:0] f;
    } vec_t;

    vec_t tbl[6];
    logic smp[$];
    int   bsy, nvec, nmis;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        smp.push_back(txd_s);
        bsy += int'(busy_s);
    endtask

    task automatic clear();
        smp.delete();
        bsy = 0;
    endtask

    // Pushes n characters on consecutive cycles, then records the line until the
    // expected frames plus one idle sample are captured (sample 0 = first start-bit cycle).
    task automatic send(input bit s, input int n, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2);
        logic [7:0] d[3];
        d = '{d0, d1, d2};
        sel = s;
        tick();
        valid = 1'b1;
        data = d0;
        tick();
        clear();
        for (int i = 1; i < n; i++) begin
            data = d[i];
            tick();
        end
        valid = 1'b0;
        while (smp.size() < n * NB * 4 + 1) tick();
    endtask

    task automatic check_stream(input int n, input logic [63:0] ef);
        int L;
        logic [63:0] got;
        bit bad;
        L = n * NB * 4;
        got = '0;
        bad = 1'b0;
        for (int k = 0; k < L; k++) begin
            if (smp[k] !== ef[k/4]) bad = 1'b1;
            if (k % 4 == 2) got[k/4] = smp[k];
        end
        if (bad) got[63] = 1'b1;
        chk("frame_bits", got, ef);
        chk("idle_after", 64'(smp[L]), 64'd1);
        chk("busy_cycles", 64'(bsy), 64'(L));
        chk("count_end", 64'(count_s), 64'd0);
        chk("ready_end", 64'(ready_s), 64'd1);
    endtask

    initial begin
        logic [11:0] f1, f2, f3;
        nvec = 0; nmis = 0; bsy = 0;
        rst_n = 1'b0; valid = 1'b0; clr = 1'b0; sel = 1'b0; data = 8'h00;
`ifdef UART_PARITY_EN
        tbl[0] = '{1'b0, 8'hA5, 12'b0_1_0_10100101_0};
        tbl[1] = '{1'b0, 8'h07, 12'b0_1_1_00000111_0};
        tbl[2] = '{1'b0, 8'h03, 12'b0_1_0_00000011_0};
        tbl[3] = '{1'b0, 8'h55, 12'b0_1_0_01010101_0};
        tbl[4] = '{1'b1, 8'h7F, 12'b0_11_1_1111111_0};
        tbl[5] = '{1'b1, 8'h00, 12'b0_11_0_0000000_0};
        f1 = 12'b0_1_1_00000001_0;
        f2 = 12'b0_1_1_00000010_0;
        f3 = 12'b0_1_0_00000011_0;
`else
        tbl[0] = '{1'b0, 8'hA5, 12'b00_1_10100101_0};
        tbl[1] = '{1'b0, 8'h07, 12'b00_1_00000111_0};
        tbl[2] = '{1'b0, 8'h03, 12'b00_1_00000011_0};
        tbl[3] = '{1'b0, 8'h55, 12'b00_1_01010101_0};
        tbl[4] = '{1'b1, 8'h7F, 12'b00_11_1111111_0};
        tbl[5] = '{1'b1, 8'h00, 12'b00_11_0000000_0};
        f1 = 12'b00_1_00000001_0;
        f2 = 12'b00_1_00000010_0;
        f3 = 12'b00_1_00000011_0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_txd", 64'(txd_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_count", 64'(count_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_ready", 64'(ready_a), 64'd1);
        chk("rst_txd_b", 64'(txd_b), 64'd1);
        chk("rst_ovf_b", 64'(ovf_b), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            send(tbl[i].sel, 1, tbl[i].d, 8'h00, 8'h00);
            check_stream(1, 64'(tbl[i].f));
        end

        send(1'b0, 3, 8'h01, 8'h02, 8'h03);
        check_stream(3, 64'(f1) | (64'(f2) << NB) | (64'(f3) << (2 * NB)));

        sel = 1'b0;
        tick();
        valid = 1'b1; data = 8'hC1;
        tick();
        clear();
        data = 8'hC2; tick();
        data = 8'hC3; tick();
        data = 8'hC4; tick();
        data = 8'hC5; tick();
        chk("full_count", 64'(count_a), 64'd4);
        chk("full_ready", 64'(ready_a), 64'd0);
        chk("full_ovf_pre", 64'(ovf_a), 64'd0);
        data = 8'hC6; tick();
        chk("ovf_set", 64'(ovf_a), 64'd1);
        chk("ovf_count", 64'(count_a), 64'd4);
        clr = 1'b1; tick();
        chk("ovf_set_wins", 64'(ovf_a), 64'd1);
        valid = 1'b0; tick();
        chk("ovf_clr", 64'(ovf_a), 64'd0);
        chk("ovf_ready", 64'(ready_a), 64'd0);
        clr = 1'b0;
        while (smp.size() < 5 * NB * 4 + 1) tick();
        chk("ovf_busy_total", 64'(bsy), 64'(5 * NB * 4));
        chk("ovf_idle", 64'(smp[5 * NB * 4]), 64'd1);
        chk("ovf_drained", 64'(count_a), 64'd0);

        sel = 1'b0;
        tick();
        valid = 1'b1; data = 8'h00; tick();
        data = 8'h02; tick();
        data = 8'h03; tick();
        valid = 1'b0;
        repeat (8) tick();
        chk("pre_rst_txd", 64'(txd_a), 64'd0);
        chk("pre_rst_count", 64'(count_a), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", 64'(txd_a), 64'd1);
        chk("mid_rst_count", 64'(count_a), 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_ready", 64'(ready_a), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 1, 8'h55, 8'h00, 8'h00);
        check_stream(1, 64'(tbl[3].f));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
